sal_timing_cfg: RTL and testbench
=================================

# sal_timing_cfg

- Run-time programmable successor of the fixed-value DDR timing configuration block.
- Holds bank and scheduler timing parameters as APB-writable shadow registers with parametrised field width, and drives the bank and scheduler timing interfaces from a separate active register set.
- Shadow values move into the active set only through a commit handshake with the scheduler, so timing never changes mid-command.
- Sits between the APB host port and the bank/scheduler timing interfaces.

## Interface

- TW, 8: width of each timing field; legal programmed values are 1..2^TW-1
- AW, 12: APB address width
- DW, 32: APB data width; TW <= 16 required
- clk input 1: the only clock
- rst_n input 1: asynchronous, active-low reset
- apb_if slave modport: psel, penable, pwrite, paddr[AW-1:0], pwdata[DW-1:0] in; prdata[DW-1:0], pready, pslverr out
- bk_timing_if output: t_rcd, t_rp, t_ras, t_rfc, t_rtp, t_wtp, each TW bits, driven from the active set
- sched_timing_if output: t_rrd, t_ccd, t_wtr, t_rtw, each TW bits, driven from the active set
- upd_req output 1: commit request to the scheduler
- upd_ack input 1: scheduler is idle and accepts the update

## Operation

- Register map (byte offsets, value in bits [TW-1:0]):
  - 0x00 T_RCD, 0x04 T_RP, 0x08 T_RAS, 0x0C T_RFC, 0x10 T_RTP, 0x14 T_WTP
  - 0x18 T_RRD, 0x1C T_CCD, 0x20 T_WTR, 0x24 T_RTW
  - 0x28 CTRL: bit0 COMMIT, write-1-to-trigger, reads 0; bit1 LOCK, only when enabled (see Configuration)
  - 0x2C STATUS, read-only: bit0 PENDING, bit1 LOCKED, bits[15:8] commit count (8-bit, wraps 255->0)
- Shadow writes:
  - A value of 0 or any nonzero bit above TW-1 gives pslverr=1; the shadow is unchanged.
  - Reads return the shadow value, zero-extended.
- Unmapped address: reads return 0 with pslverr=1; writes are dropped with pslverr=1.
- Writes to STATUS give pslverr=1.
- Commit FSM states:
  - IDLE -> REQ on an accepted COMMIT write.
  - REQ holds upd_req=1. On the cycle upd_ack=1 is sampled: active <= shadow (all 10 fields atomically), commit count increments, and the FSM returns to IDLE.
- COMMIT written while in REQ is ignored, with no error.
- Shadow writes during REQ are allowed. The active set takes the shadow contents in the ack cycle, including a write accepted in that same cycle.
- upd_ack while in IDLE is ignored.

## Timing

- APB has zero wait states: pready=1 always.
- Writes take effect on the rising edge of the access phase (psel & penable).
- prdata is registered in the setup phase and valid during the access phase. pslverr is combinational in the access phase and 0 otherwise.
- COMMIT access edge -> upd_req=1 on the next cycle.
- Ack edge -> upd_req=0 and new active values visible on the next cycle (1-cycle latency).
- Reset values:
  - Shadow and active sets hold the package default constants.
  - upd_req=0, prdata=0, STATUS=0, FSM in IDLE.
- Reset asserted mid-REQ aborts the commit: the active set returns to defaults and upd_req drops asynchronously.

## Configuration

- SAL_TIMING_CFG_LOCK_EN defined:
  - CTRL bit1 LOCK is sticky-set by software and cleared only by reset.
  - While locked, timing-register and COMMIT writes give pslverr=1 and have no effect.
  - STATUS.LOCKED reflects the bit.
- Without the macro: CTRL bit1 is ignored on write and reads 0, and STATUS.LOCKED=0.

## Structure

- SAL_TIMING_CFG_PKG holds:
  - register offset localparams
  - default timing constants taken from the DDR params macros
  - a packed struct of the 10 timing fields
  - the commit FSM state enum
- One sub-module, sal_timing_cfg_apb, holds the APB decode, pslverr generation and prdata mux. The top level holds the register sets and commit FSM.

## Test plan

- Reset, then read all 10 timing registers -> default constants; interface outputs equal the defaults; STATUS=0.
- Write T_RCD=7, COMMIT; hold upd_ack=0 for 5 cycles -> upd_req high throughout and bk t_rcd still default. Raise upd_ack -> t_rcd=7 the next cycle, upd_req=0, count=1.
- Write T_RP=0, then T_RP=1<<TW -> pslverr=1 on both; the shadow reads its prior value.
- Read 0x30 -> prdata=0, pslverr=1. Write STATUS -> pslverr=1.
- During REQ: write T_CCD=3 and a second COMMIT -> a single ack applies t_ccd=3, and count increments by 1.
- With LOCK_EN: set LOCK, then write T_RAS=20 -> pslverr=1 and no change. Apply rst_n mid-REQ -> defaults restored, upd_req=0, lock cleared.

Source files
------------

// File: rtl/sal_timing_cfg_pkg.sv
// sal_timing_cfg_pkg: register map, reset timing defaults, timing field
// struct and commit FSM encoding shared by sal_timing_cfg and its APB front end.
// Reset defaults come from the DDR_T_* parameter macros; fallbacks are used
// when the DDR parameter header has not defined them.

`ifndef DDR_T_RCD
`define DDR_T_RCD 14
`endif
`ifndef DDR_T_RP
`define DDR_T_RP 14
`endif
`ifndef DDR_T_RAS
`define DDR_T_RAS 33
`endif
`ifndef DDR_T_RFC
`define DDR_T_RFC 160
`endif
`ifndef DDR_T_RTP
`define DDR_T_RTP 8
`endif
`ifndef DDR_T_WTP
`define DDR_T_WTP 16
`endif
`ifndef DDR_T_RRD
`define DDR_T_RRD 4
`endif
`ifndef DDR_T_CCD
`define DDR_T_CCD 4
`endif
`ifndef DDR_T_WTR
`define DDR_T_WTR 8
`endif
`ifndef DDR_T_RTW
`define DDR_T_RTW 6
`endif

package sal_timing_cfg_pkg;

  localparam int NUM_T = 10;

  // Byte offsets within the register page
  localparam logic [7:0] OFS_T_RCD  = 8'h00;
  localparam logic [7:0] OFS_T_RP   = 8'h04;
  localparam logic [7:0] OFS_T_RAS  = 8'h08;
  localparam logic [7:0] OFS_T_RFC  = 8'h0C;
  localparam logic [7:0] OFS_T_RTP  = 8'h10;
  localparam logic [7:0] OFS_T_WTP  = 8'h14;
  localparam logic [7:0] OFS_T_RRD  = 8'h18;
  localparam logic [7:0] OFS_T_CCD  = 8'h1C;
  localparam logic [7:0] OFS_T_WTR  = 8'h20;
  localparam logic [7:0] OFS_T_RTW  = 8'h24;
  localparam logic [7:0] OFS_CTRL   = 8'h28;
  localparam logic [7:0] OFS_STATUS = 8'h2C;

  // Timing register offsets in storage-index order
  localparam logic [7:0] TIMING_OFS [NUM_T] = '{
    OFS_T_RCD, OFS_T_RP, OFS_T_RAS, OFS_T_RFC, OFS_T_RTP,
    OFS_T_WTP, OFS_T_RRD, OFS_T_CCD, OFS_T_WTR, OFS_T_RTW
  };

  // Fields are sized for the widest supported TW (16)
  typedef struct packed {
    logic [15:0] t_rcd;
    logic [15:0] t_rp;
    logic [15:0] t_ras;
    logic [15:0] t_rfc;
    logic [15:0] t_rtp;
    logic [15:0] t_wtp;
    logic [15:0] t_rrd;
    logic [15:0] t_ccd;
    logic [15:0] t_wtr;
    logic [15:0] t_rtw;
  } timing_t;

  localparam timing_t TIMING_DEFAULT = '{
    t_rcd: 16'(`DDR_T_RCD), t_rp:  16'(`DDR_T_RP),  t_ras: 16'(`DDR_T_RAS),
    t_rfc: 16'(`DDR_T_RFC), t_rtp: 16'(`DDR_T_RTP), t_wtp: 16'(`DDR_T_WTP),
    t_rrd: 16'(`DDR_T_RRD), t_ccd: 16'(`DDR_T_CCD), t_wtr: 16'(`DDR_T_WTR),
    t_rtw: 16'(`DDR_T_RTW)
  };

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } commit_state_t;

  // Default value for a timing field by storage index
  function automatic logic [15:0] timing_default(input int unsigned idx);
    case (idx)
      0:       return TIMING_DEFAULT.t_rcd;
      1:       return TIMING_DEFAULT.t_rp;
      2:       return TIMING_DEFAULT.t_ras;
      3:       return TIMING_DEFAULT.t_rfc;
      4:       return TIMING_DEFAULT.t_rtp;
      5:       return TIMING_DEFAULT.t_wtp;
      6:       return TIMING_DEFAULT.t_rrd;
      7:       return TIMING_DEFAULT.t_ccd;
      8:       return TIMING_DEFAULT.t_wtr;
      default: return TIMING_DEFAULT.t_rtw;
    endcase
  endfunction

endpackage

// File: rtl/sal_timing_cfg_apb.sv
// sal_timing_cfg_apb: zero-wait-state APB decode for the timing register page.
// Produces write strobes for the owning register sets, the error response and
// the registered read data (captured in the setup phase).

module sal_timing_cfg_apb
  import sal_timing_cfg_pkg::*;
#(
  parameter int TW = 8,
  parameter int AW = 12,
  parameter int DW = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     psel,
  input  logic                     penable,
  input  logic                     pwrite,
  input  logic [AW-1:0]            paddr,
  input  logic [DW-1:0]            pwdata,
  output logic [DW-1:0]            prdata,
  output logic                     pready,
  output logic                     pslverr,
  input  logic [NUM_T-1:0][TW-1:0] shadow,
  input  logic                     pending,
  input  logic                     locked,
  input  logic [7:0]               commit_cnt,
  output logic [NUM_T-1:0]         wr_en,
  output logic [TW-1:0]            wr_val,
  output logic                     commit_wr,
  output logic                     lock_wr
);

  logic             setup;
  logic             access;
  logic             in_page;
  logic [NUM_T-1:0] hit_t;
  logic             hit_ctrl;
  logic             hit_status;
  logic             mapped;
  logic             val_ok;
  logic [DW-1:0]    rdata;

  assign setup      = psel & ~penable;
  assign access     = psel & penable;
  assign in_page    = (paddr[AW-1:8] == '0);
  assign hit_ctrl   = in_page && (paddr[7:0] == OFS_CTRL);
  assign hit_status = in_page && (paddr[7:0] == OFS_STATUS);
  assign mapped     = (|hit_t) | hit_ctrl | hit_status;

  // A timing value must be nonzero and fit in TW bits
  assign val_ok = (pwdata[TW-1:0] != '0) && (pwdata[DW-1:TW] == '0);

  // One-hot decode of the timing register offsets
  always_comb begin
    hit_t = '0;
    for (int i = 0; i < NUM_T; i++) begin
      hit_t[i] = in_page && (paddr[7:0] == TIMING_OFS[i]);
    end
  end

  assign wr_en     = (access & pwrite & ~locked & val_ok) ? hit_t : '0;
  assign wr_val    = pwdata[TW-1:0];
  assign commit_wr = access & pwrite & hit_ctrl & pwdata[0] & ~locked;
  assign lock_wr   = access & pwrite & hit_ctrl & pwdata[1];

  assign pready  = 1'b1;
  assign pslverr = access & (~mapped |
                   (pwrite & (hit_status |
                              ((|hit_t) & (~val_ok | locked)) |
                              (hit_ctrl & pwdata[0] & locked))));

  // Read mux; COMMIT always reads back as 0
  always_comb begin
    rdata = '0;
    for (int i = 0; i < NUM_T; i++) begin
      if (hit_t[i]) rdata[TW-1:0] = shadow[i];
    end
    if (hit_ctrl) rdata[1] = locked;
    if (hit_status) begin
      rdata[0]    = pending;
      rdata[1]    = locked;
      rdata[15:8] = commit_cnt;
    end
  end

  // Capture read data in the setup phase so it is stable for the access phase
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prdata <= '0;
    end else if (setup) begin
      prdata <= rdata;
    end
  end

endmodule

// File: rtl/sal_timing_cfg.sv
// sal_timing_cfg: run-time programmable DDR timing configuration.
// APB-writable shadow registers are copied atomically into the active set that
// drives the bank/scheduler timing outputs, only when the scheduler acks a
// commit request. Optional software lock: define SAL_TIMING_CFG_LOCK_EN.
//
// state   | meaning
// IDLE    | no commit outstanding, upd_req low
// REQ     | commit requested, upd_req high until upd_ack is sampled

module sal_timing_cfg
  import sal_timing_cfg_pkg::*;
#(
  parameter int TW = 8,
  parameter int AW = 12,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          psel,
  input  logic          penable,
  input  logic          pwrite,
  input  logic [AW-1:0] paddr,
  input  logic [DW-1:0] pwdata,
  output logic [DW-1:0] prdata,
  output logic          pready,
  output logic          pslverr,
  output logic [TW-1:0] t_rcd,
  output logic [TW-1:0] t_rp,
  output logic [TW-1:0] t_ras,
  output logic [TW-1:0] t_rfc,
  output logic [TW-1:0] t_rtp,
  output logic [TW-1:0] t_wtp,
  output logic [TW-1:0] t_rrd,
  output logic [TW-1:0] t_ccd,
  output logic [TW-1:0] t_wtr,
  output logic [TW-1:0] t_rtw,
  output logic          upd_req,
  input  logic          upd_ack
);

  function automatic logic [NUM_T-1:0][TW-1:0] dflt_set();
    logic [NUM_T-1:0][TW-1:0] r;
    for (int i = 0; i < NUM_T; i++) r[i] = TW'(timing_default(i));
    return r;
  endfunction

  localparam logic [NUM_T-1:0][TW-1:0] DFLT = dflt_set();

  logic [NUM_T-1:0][TW-1:0] shadow_q;
  logic [NUM_T-1:0][TW-1:0] shadow_d;
  logic [NUM_T-1:0][TW-1:0] active_q;
  logic [NUM_T-1:0]         wr_en;
  logic [TW-1:0]            wr_val;
  logic                     commit_wr;
  logic                     lock_wr;
  logic                     locked;
  logic [7:0]               commit_cnt_q;
  logic                     ack_take;
  commit_state_t            state_q;
  commit_state_t            state_d;

  sal_timing_cfg_apb #(.TW(TW), .AW(AW), .DW(DW)) u_apb (
    .clk        (clk),
    .rst_n      (rst_n),
    .psel       (psel),
    .penable    (penable),
    .pwrite     (pwrite),
    .paddr      (paddr),
    .pwdata     (pwdata),
    .prdata     (prdata),
    .pready     (pready),
    .pslverr    (pslverr),
    .shadow     (shadow_q),
    .pending    (upd_req),
    .locked     (locked),
    .commit_cnt (commit_cnt_q),
    .wr_en      (wr_en),
    .wr_val     (wr_val),
    .commit_wr  (commit_wr),
    .lock_wr    (lock_wr)
  );

  assign ack_take = (state_q == ST_REQ) && upd_ack;

  // Next shadow contents; the active copy in an ack cycle sees this value
  always_comb begin
    shadow_d = shadow_q;
    for (int i = 0; i < NUM_T; i++) begin
      if (wr_en[i]) shadow_d[i] = wr_val;
    end
  end

  // Shadow, active set and commit counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q     <= DFLT;
      active_q     <= DFLT;
      commit_cnt_q <= '0;
    end else begin
      shadow_q <= shadow_d;
      if (ack_take) begin
        active_q     <= shadow_d;
        commit_cnt_q <= commit_cnt_q + 8'd1;
      end
    end
  end

`ifdef SAL_TIMING_CFG_LOCK_EN
  logic lock_q;

  // Sticky lock, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_q <= 1'b0;
    end else if (lock_wr) begin
      lock_q <= 1'b1;
    end
  end

  assign locked = lock_q;
`else
  logic unused_lock_wr;
  assign unused_lock_wr = lock_wr;
  assign locked         = 1'b0;
`endif

  // Commit FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Commit FSM next state; COMMIT in REQ and ack in IDLE are ignored
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (commit_wr) state_d = ST_REQ;
      ST_REQ:  if (upd_ack)   state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Commit FSM outputs
  always_comb begin
    upd_req = (state_q == ST_REQ);
  end

  assign t_rcd = active_q[0];
  assign t_rp  = active_q[1];
  assign t_ras = active_q[2];
  assign t_rfc = active_q[3];
  assign t_rtp = active_q[4];
  assign t_wtp = active_q[5];
  assign t_rrd = active_q[6];
  assign t_ccd = active_q[7];
  assign t_wtr = active_q[8];
  assign t_rtw = active_q[9];

endmodule

// File: tb/tb_sal_timing_cfg.sv
// tb_sal_timing_cfg: scoreboard bench for sal_timing_cfg. A reference model
// predicts each APB response when the transfer is issued; the prediction is
// queued and compared in the access phase. Timing outputs are compared
// against the model's active set.

module tb_sal_timing_cfg;

  localparam int TW = 8;
  localparam int AW = 12;
  localparam int DW = 32;

  localparam logic [11:0] A_CTRL   = 12'h028;
  localparam logic [11:0] A_STATUS = 12'h02C;

`ifdef SAL_TIMING_CFG_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  localparam logic [7:0] DFLT [10] = '{8'd14, 8'd14, 8'd33, 8'd160, 8'd8,
                                       8'd16, 8'd4,  8'd4,  8'd8,   8'd6};

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          psel = 1'b0;
  logic          penable = 1'b0;
  logic          pwrite = 1'b0;
  logic [AW-1:0] paddr = '0;
  logic [DW-1:0] pwdata = '0;
  logic [DW-1:0] prdata;
  logic          pready;
  logic          pslverr;
  logic [TW-1:0] t_rcd, t_rp, t_ras, t_rfc, t_rtp, t_wtp;
  logic [TW-1:0] t_rrd, t_ccd, t_wtr, t_rtw;
  logic          upd_req;
  logic          upd_ack = 1'b0;

  sal_timing_cfg #(.TW(TW), .AW(AW), .DW(DW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .psel    (psel),
    .penable (penable),
    .pwrite  (pwrite),
    .paddr   (paddr),
    .pwdata  (pwdata),
    .prdata  (prdata),
    .pready  (pready),
    .pslverr (pslverr),
    .t_rcd   (t_rcd),
    .t_rp    (t_rp),
    .t_ras   (t_ras),
    .t_rfc   (t_rfc),
    .t_rtp   (t_rtp),
    .t_wtp   (t_wtp),
    .t_rrd   (t_rrd),
    .t_ccd   (t_ccd),
    .t_wtr   (t_wtr),
    .t_rtw   (t_rtw),
    .upd_req (upd_req),
    .upd_ack (upd_ack)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model
  logic [7:0] sh_m [10];
  logic [7:0] ac_m [10];
  logic [7:0] cnt_m;
  bit         pend_m;
  bit         lock_m;

  function automatic void model_reset();
    for (int i = 0; i < 10; i++) begin
      sh_m[i] = DFLT[i];
      ac_m[i] = DFLT[i];
    end
    cnt_m  = 8'd0;
    pend_m = 1'b0;
    lock_m = 1'b0;
  endfunction

  function automatic logic model_write(input logic [11:0] a, input logic [31:0] d);
    logic err;
    int   idx;
    err = 1'b1;
    idx = int'(a[5:2]);
    if (a[1:0] == 2'b00 && a < 12'h030) begin
      if (idx < 10) begin
        err = (d == 32'd0) || ((d >> TW) != 32'd0) || lock_m;
        if (!err) sh_m[idx] = d[7:0];
      end else if (idx == 10) begin
        err = d[0] && lock_m;
        if (!err) begin
          if (d[0]) pend_m = 1'b1;
          if (d[1] && LOCK_EN) lock_m = 1'b1;
        end
      end
    end
    return err;
  endfunction

  function automatic void model_read(input logic [11:0] a, output logic [31:0] rd,
                                     output logic err);
    int idx;
    idx = int'(a[5:2]);
    rd  = 32'd0;
    err = 1'b1;
    if (a[1:0] == 2'b00 && a < 12'h030) begin
      err = 1'b0;
      if (idx < 10)       rd = {24'd0, sh_m[idx]};
      else if (idx == 10) rd = {30'd0, lock_m, 1'b0};
      else                rd = {16'd0, cnt_m, 6'd0, lock_m, pend_m};
    end
  endfunction

  function automatic void model_ack();
    if (pend_m) begin
      for (int i = 0; i < 10; i++) ac_m[i] = sh_m[i];
      cnt_m  = cnt_m + 8'd1;
      pend_m = 1'b0;
    end
  endfunction

  typedef struct {
    string       tag;
    logic [31:0] rdata;
    logic        err;
    bit          chk_rd;
  } exp_t;

  exp_t sb_q [$];

  // One APB transfer; the expected response is popped in the access phase
  task automatic apb(input logic wr, input logic [11:0] a, input logic [31:0] d,
                     input logic ack_acc);
    exp_t e;
    psel    = 1'b1;
    penable = 1'b0;
    pwrite  = wr;
    paddr   = a;
    pwdata  = d;
    @(posedge clk); #1;
    penable = 1'b1;
    upd_ack = ack_acc;
    #1;
    if (sb_q.size() == 0) begin
      chk("sb_underflow", 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      chk({e.tag, "_err"}, {31'd0, pslverr}, {31'd0, e.err});
      if (e.chk_rd) chk({e.tag, "_rd"}, prdata, e.rdata);
    end
    @(posedge clk); #1;
    psel    = 1'b0;
    penable = 1'b0;
    pwrite  = 1'b0;
    upd_ack = 1'b0;
  endtask

  task automatic wr(input string tag, input logic [11:0] a, input logic [31:0] d,
                    input logic ack_acc = 1'b0);
    exp_t e;
    e.tag    = tag;
    e.err    = model_write(a, d);
    e.rdata  = 32'd0;
    e.chk_rd = 1'b0;
    sb_q.push_back(e);
    apb(1'b1, a, d, ack_acc);
    if (ack_acc) model_ack();
  endtask

  task automatic rd(input string tag, input logic [11:0] a);
    exp_t e;
    e.tag    = tag;
    model_read(a, e.rdata, e.err);
    e.chk_rd = 1'b1;
    sb_q.push_back(e);
    apb(1'b0, a, 32'd0, 1'b0);
  endtask

  function automatic logic [7:0] port_val(input int i);
    case (i)
      0: return t_rcd;
      1: return t_rp;
      2: return t_ras;
      3: return t_rfc;
      4: return t_rtp;
      5: return t_wtp;
      6: return t_rrd;
      7: return t_ccd;
      8: return t_wtr;
      default: return t_rtw;
    endcase
  endfunction

  task automatic chk_outs(input string tag);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("%s_t%0d", tag, i), {24'd0, port_val(i)}, {24'd0, ac_m[i]});
    end
    chk({tag, "_req"}, {31'd0, upd_req}, {31'd0, pend_m});
  endtask

  task automatic do_ack();
    upd_ack = 1'b1;
    @(posedge clk); #1;
    upd_ack = 1'b0;
    model_ack();
    chk("ack_req_low", {31'd0, upd_req}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_upd_req", {31'd0, upd_req}, 32'd0);
    chk("rst_prdata", prdata, 32'd0);
    chk("rst_pslverr", {31'd0, pslverr}, 32'd0);
    chk("rst_pready", {31'd0, pready}, 32'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Defaults on readback and on the timing outputs
    for (int i = 0; i < 10; i++) rd($sformatf("dflt_r%0d", i), 12'(i * 4));
    rd("status_rst", A_STATUS);
    chk_outs("dflt_out");

    // Commit held off by the scheduler
    wr("w_rcd7", 12'h000, 32'd7);
    wr("commit1", A_CTRL, 32'd1);
    for (int c = 0; c < 5; c++) begin
      chk("hold_req", {31'd0, upd_req}, 32'd1);
      chk("hold_rcd", {24'd0, t_rcd}, {24'd0, DFLT[0]});
      @(posedge clk); #1;
    end
    rd("status_pend", A_STATUS);
    do_ack();
    chk_outs("ack1_out");
    rd("status_cnt1", A_STATUS);

    // Illegal values and the largest legal value
    wr("w_rp0", 12'h004, 32'd0);
    wr("w_rp_ovf", 12'h004, 32'd1 << TW);
    rd("r_rp_keep", 12'h004);
    wr("w_rfc_max", 12'h00C, 32'd255);
    wr("w_rfc_ovf", 12'h00C, 32'h1FF);
    rd("r_rfc_max", 12'h00C);

    // Unmapped, misaligned, read-only and CTRL readback
    rd("r_unmapped", 12'h030);
    rd("r_misalign", 12'h002);
    rd("r_hi_page", 12'h100);
    wr("w_status", A_STATUS, 32'd1);
    wr("w_unmapped", 12'h03C, 32'd5);
    rd("r_ctrl", A_CTRL);

    // Shadow write and second COMMIT while REQ: one ack applies both
    wr("commit2", A_CTRL, 32'd1);
    wr("w_ccd3", 12'h01C, 32'd3);
    wr("commit2_dup", A_CTRL, 32'd1);
    chk("req2_ccd_old", {24'd0, t_ccd}, {24'd0, DFLT[7]});
    do_ack();
    chk_outs("ack2_out");
    repeat (3) @(posedge clk);
    #1;
    chk("no_second_req", {31'd0, upd_req}, 32'd0);
    rd("status_cnt2", A_STATUS);

    // Shadow write accepted in the ack cycle reaches the active set
    wr("commit3", A_CTRL, 32'd1);
    wr("w_wtr9_ack", 12'h020, 32'd9, 1'b1);
    chk_outs("ack3_out");

    // upd_ack while idle does nothing
    wr("w_rtw11", 12'h024, 32'd11);
    upd_ack = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    upd_ack = 1'b0;
    chk_outs("idle_ack_out");
    rd("status_cnt3", A_STATUS);

    // Enter REQ, exercise the lock bit, then reset mid-REQ
    wr("w_rcd50", 12'h000, 32'd50);
    wr("commit4", A_CTRL, 32'd1);
    chk("req4", {31'd0, upd_req}, 32'd1);
    wr("w_lock", A_CTRL, 32'd2);
    rd("r_ctrl_lock", A_CTRL);
    rd("status_lock", A_STATUS);
    wr("w_ras20", 12'h008, 32'd20);
    rd("r_ras", 12'h008);
    wr("commit_locked", A_CTRL, 32'd1);

    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_mid_req", {31'd0, upd_req}, 32'd0);
    chk_outs("rst_mid_out");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    rd("r_rcd_after_rst", 12'h000);
    rd("status_after_rst", A_STATUS);
    wr("w_ras20_unlocked", 12'h008, 32'd20);
    rd("r_ras_unlocked", 12'h008);
    chk("sb_drained", sb_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
